// File: rtl/md_defs.sv
// Shared op and FSM state encodings for the multiply/divide unit,
// plus the counter width helper.
package md_defs;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_RSV6  = 3'b110,
      OP_RSV7  = 3'b111
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   // Bits needed to hold the longer of the two busy durations.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product / quotient-remainder generation, signed and
// unsigned, including the divide-by-zero result.
module md_calc
   import md_defs::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic        sgn;
   logic [31:0] ma, mb, qm, rm, q, r;
   logic [63:0] pm, prod;

   // Work on magnitudes so signed and unsigned share one datapath; this also
   // makes 0x80000000 / -1 fall out as 0x80000000 with remainder 0.
   assign sgn  = (op == OP_MULT) || (op == OP_DIV);
   assign ma   = (sgn && a[31]) ? (~a + 32'd1) : a;
   assign mb   = (sgn && b[31]) ? (~b + 32'd1) : b;
   assign pm   = {32'b0, ma} * {32'b0, mb};
   assign prod = (sgn && (a[31] ^ b[31])) ? (~pm + 64'd1) : pm;
   assign qm   = (mb == 32'd0) ? 32'd0 : ma / mb;
   assign rm   = (mb == 32'd0) ? 32'd0 : ma % mb;
   assign q    = (sgn && (a[31] ^ b[31])) ? (~qm + 32'd1) : qm;
   assign r    = (sgn && a[31]) ? (~rm + 32'd1) : rm;

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         OP_MULT, OP_MULTU: {hi, lo} = prod;
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               hi = r;
               lo = q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: IDLE/BUSY FSM that latches the result at acceptance,
// holds busy for a fixed latency, then commits HI/LO and pulses done.
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output md_state_t   dbg_state
);

   localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

   md_state_t   state;
   logic [CW-1:0] cnt;
   logic [31:0] res_hi, res_lo;
   logic [31:0] calc_hi, calc_lo;

   md_calc u_calc (
      .op (op),
      .a  (A),
      .b  (B),
      .hi (calc_hi),
      .lo (calc_lo)
   );

   assign dbg_state = state;

   // start is honoured only in IDLE; while BUSY every op, MTHI/MTLO included,
   // is dropped and operands are not captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         HI     <= 32'd0;
         LO     <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (md_op_t'(op))
                     OP_MULT, OP_MULTU: begin
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        cnt    <= CW'(MULT_CYCLES);
                        busy   <= 1'b1;
                        state  <= ST_BUSY;
                     end
                     OP_DIV, OP_DIVU: begin
                        res_hi <= calc_hi;
                        res_lo <= calc_lo;
                        cnt    <= CW'(DIV_CYCLES);
                        busy   <= 1'b1;
                        state  <= ST_BUSY;
                     end
                     OP_MTHI: HI <= A;
                     OP_MTLO: LO <= A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (cnt == CW'(1)) begin
                  HI    <= res_hi;
                  LO    <= res_lo;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed and random mul/div ops with a
// scoreboard of expected {HI,LO} popped on each done pulse.
module tb_md_unit;
   import md_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] HI, LO;
   md_state_t   dbg_state;

   int          n_vectors = 0;
   int          n_miscompares = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;
   logic        prev_done = 1'b0;
   logic [63:0] mon_e;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .HI        (HI),
      .LO        (LO),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vectors++;
      if (obs !== expv) begin
         n_miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sp;
      int     q, r;
      case (o)
         3'd0: begin
            sp = longint'(int'(a)) * longint'(int'(b));
            return sp;
         end
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {r, q};
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         if (prev_done) check("done_width", {31'b0, done}, 32'd0);
         if (done) begin
            if (exp_q.size() == 0) begin
               check("done_unexp", {31'b0, done}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_hi", HI, mon_e[63:32]);
               check("sb_lo", LO, mon_e[31:0]);
            end
         end
      end
      prev_done = done;
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge of the done cycle. inj>0
   // drives an MTLO A=5 during that busy cycle, which must be ignored.
   task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int n, input int inj);
      logic [63:0] e;
      int          cnt;
      logic        stable;
      e = model(o, a, b);
      start = 1'b1; op = o; A = a; B = b;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
      cnt = 0;
      stable = 1'b1;
      @(negedge clk);
      check("state_busy", {31'b0, dbg_state == ST_BUSY}, 32'd1);
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (HI !== exp_hi || LO !== exp_lo) stable = 1'b0;
         if (cnt == inj) begin
            start = 1'b1; op = OP_MTLO; A = 32'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_len", cnt, n);
      check("hold_hilo", {31'b0, stable}, 32'd1);
      check("done_pulse", {31'b0, done}, 32'd1);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      start = 1'b1; op = o; A = a;
      @(posedge clk); #1;
      start = 1'b0;
      if (o == OP_MTHI) exp_hi = a;
      else exp_lo = a;
      @(negedge clk);
      check("mt_hi", HI, exp_hi);
      check("mt_lo", LO, exp_lo);
      check("mt_busy", {31'b0, busy}, 32'd0);
      check("mt_done", {31'b0, done}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int          dn;

      reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
      #3;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_state", {31'b0, dbg_state == ST_IDLE}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // first edge with reset released accepts the op
      run_md(OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 0);
      @(negedge clk) run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 0);
      @(negedge clk) run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 0);
      @(negedge clk) run_md(OP_DIVU,  32'd7, 32'd0, 10, 0);
      @(negedge clk) run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
      @(negedge clk) run_md(OP_DIV,   32'd100, 32'hFFFF_FFF9, 10, 0);
      @(negedge clk) run_md(OP_MULT,  32'h0000_1234, 32'h0000_5678, 5, 2);

      @(negedge clk) mt(OP_MTHI, 32'h1234_5678);
      run_md(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 0);
      run_md(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 10, 0);
      @(negedge clk) mt(OP_MTLO, 32'hCAFE_F00D);

      // reserved op changes nothing
      start = 1'b1; op = OP_RSV6; A = 32'hDEAD_BEEF; B = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("rsv_busy", {31'b0, busy}, 32'd0);
      check("rsv_hi", HI, exp_hi);
      check("rsv_lo", LO, exp_lo);

      for (int i = 0; i < 12; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         @(negedge clk) run_md(ro, ra, rb, (ro < 3'd2) ? 5 : 10, 0);
      end

      // reset pulsed mid-cycle during busy cycle 4 of a DIVU
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_hi", HI, 32'd0);
      check("mid_rst_lo", LO, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      dn = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("mid_rst_nodone", dn, 0);
      check("post_rst_hi", HI, 32'd0);
      check("post_rst_lo", LO, 32'd0);

      run_md(OP_MULTU, 32'd1000, 32'd1000, 5, 0);
      @(negedge clk);
      check("q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles busy is high for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: cycles busy is high for DIV/DIVU.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low.
REQ-005 Port start, input, 1: request strobe, sampled on the rising edge together with op, A and B.
REQ-006 Port op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-007 Port A, input, 32: multiplicand, dividend, or MTHI/MTLO source.
REQ-008 Port B, input, 32: multiplier or divisor.
REQ-009 Port busy, output, 1: high while a multiply or divide is in flight.
REQ-010 Port done, output, 1: single-cycle pulse in the cycle after HI/LO commit.
REQ-011 Port HI, output, 32: architectural HI register.
REQ-012 Port LO, output, 32: architectural LO register.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE and BUSY.
REQ-014 IDLE, start=1, op in {MULT, MULTU}: latch the 64-bit product of A and B (signed for MULT, unsigned for MULTU), load the counter with MULTU_CYCLES... SHALL load the counter with MULT_CYCLES, and go to BUSY.
REQ-015 IDLE, start=1, op in {DIV, DIVU}: latch quotient and remainder (signed for DIV, unsigned for DIVU), load the counter with DIV_CYCLES, and go to BUSY.
REQ-016 Signed DIV SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-017 Divide by zero SHALL latch HI=A and LO=32'hFFFFFFFF; busy timing is unchanged.
REQ-018 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-019 IDLE, start=1, op=MTHI: HI SHALL take A at that edge; no busy, no done.
REQ-020 IDLE, start=1, op=MTLO: LO SHALL take A at that edge; no busy, no done.
REQ-021 IDLE, start=1, op reserved: no state change.
REQ-022 Product/divide results: HI=upper 32 bits of the product, or the remainder; LO=lower 32 bits of the product, or the quotient.
REQ-023 busy SHALL be a registered output, high for exactly N consecutive cycles starting the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-024 HI and LO SHALL update at the edge that ends BUSY, and SHALL NOT change while busy=1.
REQ-025 done SHALL be high for exactly one cycle, the cycle after that commit edge.
REQ-026 start while busy=1 SHALL be ignored for every op, including MTHI/MTLO; operands are not captured.
REQ-027 start in the cycle after busy falls SHALL be accepted, giving back-to-back operation with one idle cycle minimum.
REQ-028 A and B SHALL be sampled only at the accepting edge; later changes to A and B SHALL NOT affect the result.

Reset
REQ-029 While reset=0, state SHALL be IDLE and busy, done, HI, LO and the counter SHALL all be 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard the pending result; HI and LO read 0 after release.
REQ-031 The first start is accepted at the first rising edge with reset=1.

Structure
REQ-032 The op encodings and the FSM state encodings SHALL live in a shared package/header (md_defs), also used by ctrl.
REQ-033 One sub-module md_calc (combinational 64-bit result generation, signed and unsigned) SHALL be instantiated; the FSM, counter and HI/LO registers stay in md_unit.
REQ-034 The counter width SHALL be derived from max(MULT_CYCLES, DIV_CYCLES).

Verification
REQ-035 MULT A=32'hFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, done pulses once.
REQ-036 MULTU A=32'hFFFFFFFF, B=2 -> HI=1, LO=32'hFFFFFFFE after 5 busy cycles.
REQ-037 DIV A=-7, B=2 -> after 10 busy cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU A=7, B=0 -> HI=7, LO=32'hFFFFFFFF.
REQ-038 MULT accepted, then MTLO A=5 at busy cycle 2 -> MTLO ignored; LO=product at commit.
REQ-039 DIVU started, reset pulsed low mid-cycle at busy cycle 4 -> busy, HI, LO =0 immediately; no done.
REQ-040 MTHI A=32'h12345678 in IDLE -> HI=32'h12345678 next cycle, busy stays 0; then MULT started the cycle after done -> accepted.
